decode_fields_pipe: RTL and testbench

- Registered, parametrised instruction-field decoder forming the IF/ID boundary of the 5-stage pipeline.
- Accepts fetched instructions with a PC over a valid/ready handshake and splits each into opcode, rd, funct3, rs1, rs2 and funct7.
- Also classifies the instruction format and produces the sign-extended immediate, so ID no longer needs a separate immediate generator.
- A 2-entry skid buffer gives full throughput under downstream stalls. A flush input supports branch redirect from EX.

---
 rtl/decode_pkg.sv | 43 ++++
 rtl/decode_fields_pipe_imm_fmt_decode.sv | 57 +++++
 rtl/decode_fields_pipe.sv | 144 ++++++++++++++
 tb/tb_decode_fields_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the IF/ID field decoder: opcodes, format codes
// and the decoded-entry record held in the pipeline registers.
package decode_pkg;

    // Widest XLEN/PC supported; narrower instances use the low bits only.
    localparam int MAX_XLEN = 64;
    localparam int MAX_PC_W = 64;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_t;

    typedef struct packed {
        logic [MAX_PC_W-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        fmt_t                fmt;
        logic [MAX_XLEN-1:0] imm;
        logic                illegal;
    } dec_t;

endpackage

// File: rtl/decode_fields_pipe_imm_fmt_decode.sv
// Combinational format classifier and immediate generator for one
// 32-bit instruction. Unknown opcodes (including any with instr[1:0]
// other than 2'b11) classify as BAD with a zero immediate.
module imm_fmt_decode
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    fmt_t fmt_c;

    // Classify by opcode and assemble the sign-extended immediate.
    always_comb begin
        fmt_c = FMT_BAD;
        imm   = '0;
        case (instr[6:0])
            OP_REG: begin
                fmt_c = FMT_R;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt_c = FMT_I;
                imm   = XLEN'($signed(instr[31:20]));
            end
            OP_STORE: begin
                fmt_c = FMT_S;
                imm   = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                fmt_c = FMT_B;
                imm   = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt_c = FMT_U;
                imm   = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt_c = FMT_J;
                imm   = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0}));
            end
            default: begin
                fmt_c = FMT_BAD;
                imm   = '0;
            end
        endcase
    end

    assign fmt     = fmt_c;
    assign illegal = (fmt_c == FMT_BAD);

endmodule

// File: rtl/decode_fields_pipe.sv
// IF/ID boundary register: decodes fetched instructions before
// registration and holds up to two decoded entries (output register A
// plus skid register B) so the stage runs at full rate under stalls.
module decode_fields_pipe
    import decode_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int PC_W          = 32,
    parameter int CHECK_ILLEGAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

    occ_t            state;
    dec_t            a_q;
    dec_t            b_q;
    dec_t            dec_in;
    logic            out_valid_q;
    logic            in_ready_q;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            accept;
    logic            pop;
    logic            unused_bits;

    imm_fmt_decode #(
        .XLEN(XLEN)
    ) u_imm_fmt_decode (
        .instr  (in_instr),
        .fmt    (dec_fmt),
        .imm    (dec_imm),
        .illegal(dec_illegal)
    );

    // Pack the incoming instruction's fields into a decoded entry.
    always_comb begin
        dec_in                = '0;
        dec_in.pc[PC_W-1:0]   = in_pc;
        dec_in.opcode         = in_instr[6:0];
        dec_in.rd             = in_instr[11:7];
        dec_in.funct3         = in_instr[14:12];
        dec_in.rs1            = in_instr[19:15];
        dec_in.rs2            = in_instr[24:20];
        dec_in.funct7         = in_instr[31:25];
        dec_in.fmt            = fmt_t'(dec_fmt);
        dec_in.imm[XLEN-1:0]  = dec_imm;
        dec_in.illegal        = (CHECK_ILLEGAL != 0) ? dec_illegal : 1'b0;
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Occupancy FSM moving entries between input, skid and output regs;
    // flush discards everything, including this cycle's input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
        end else if (flush) begin
            state       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        a_q         <= dec_in;
                        state       <= OCC_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        a_q <= dec_in;
                    end else if (accept) begin
                        b_q        <= dec_in;
                        state      <= OCC_TWO;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state       <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        a_q        <= b_q;
                        state      <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= OCC_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = a_q.pc[PC_W-1:0];
    assign out_opcode  = a_q.opcode;
    assign out_rd      = a_q.rd;
    assign out_funct3  = a_q.funct3;
    assign out_rs1     = a_q.rs1;
    assign out_rs2     = a_q.rs2;
    assign out_funct7  = a_q.funct7;
    assign out_fmt     = a_q.fmt;
    assign out_imm     = a_q.imm[XLEN-1:0];
    assign out_illegal = a_q.illegal;

    // Upper bits of the max-width record fields are constant zero.
    assign unused_bits = ^{a_q.pc, a_q.imm, dec_illegal};

endmodule

// File: tb/tb_decode_fields_pipe.sv
// Directed testbench for decode_fields_pipe: decoding of each format,
// skid behaviour under stalls, flush, BAD instructions and async reset.
module tb_decode_fields_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;

    logic        n_in_ready;
    logic        n_out_valid;
    logic [31:0] n_out_pc;
    logic [6:0]  n_out_opcode;
    logic [4:0]  n_out_rd;
    logic [2:0]  n_out_funct3;
    logic [4:0]  n_out_rs1;
    logic [4:0]  n_out_rs2;
    logic [6:0]  n_out_funct7;
    logic [2:0]  n_out_fmt;
    logic [31:0] n_out_imm;
    logic        n_out_illegal;

    int checks = 0;
    int errors = 0;

    decode_fields_pipe #(
        .XLEN(32), .PC_W(32), .CHECK_ILLEGAL(1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct7(out_funct7), .out_fmt(out_fmt), .out_imm(out_imm),
        .out_illegal(out_illegal)
    );

    decode_fields_pipe #(
        .XLEN(32), .PC_W(32), .CHECK_ILLEGAL(0)
    ) dut_noill (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_pc(n_out_pc), .out_opcode(n_out_opcode), .out_rd(n_out_rd),
        .out_funct3(n_out_funct3), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
        .out_funct7(n_out_funct7), .out_fmt(n_out_fmt), .out_imm(n_out_imm),
        .out_illegal(n_out_illegal)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h",
                     tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic rdy,
                                 input logic fl);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected decode of one entry on the primary instance.
    task automatic checkEntry(input string tag, input logic [31:0] pc,
                              input logic [6:0] opc, input logic [4:0] rd,
                              input logic [2:0] fmt, input logic [31:0] imm,
                              input logic ill);
        checkOutput({tag, ".valid"},   64'(out_valid),   64'(1'b1));
        checkOutput({tag, ".pc"},      64'(out_pc),      64'(pc));
        checkOutput({tag, ".opcode"},  64'(out_opcode),  64'(opc));
        checkOutput({tag, ".rd"},      64'(out_rd),      64'(rd));
        checkOutput({tag, ".fmt"},     64'(out_fmt),     64'(fmt));
        checkOutput({tag, ".imm"},     64'(out_imm),     64'(imm));
        checkOutput({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    initial begin
        $display("[TB] starting decode_fields_pipe bench");
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, then an idle cycle.
        step();
        checkOutput("rst.valid",   64'(out_valid),   64'(1'b0));
        checkOutput("rst.ready",   64'(in_ready),    64'(1'b1));
        checkOutput("rst.opcode",  64'(out_opcode),  64'(7'h0));
        checkOutput("rst.pc",      64'(out_pc),      64'(32'h0));
        checkOutput("rst.fmt",     64'(out_fmt),     64'(3'd0));
        checkOutput("rst.imm",     64'(out_imm),     64'(32'h0));
        checkOutput("rst.illegal", 64'(out_illegal), 64'(1'b0));

        // addi x1,x0,-1
        applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
        step();
        checkEntry("addi", 32'h100, 7'h13, 5'd1, 3'd1, 32'hFFFFFFFF, 1'b0);
        checkOutput("addi.rs1", 64'(out_rs1), 64'(5'd0));

        // Back-to-back S, B, U, J at one per cycle.
        applyStimulus(1'b1, 32'h0020A423, 32'h104, 1'b1, 1'b0);
        step();
        checkEntry("sw", 32'h104, 7'h23, 5'd8, 3'd2, 32'h8, 1'b0);
        checkOutput("sw.rs1", 64'(out_rs1), 64'(5'd1));
        checkOutput("sw.rs2", 64'(out_rs2), 64'(5'd2));
        applyStimulus(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0);
        step();
        checkEntry("beq", 32'h108, 7'h63, 5'd29, 3'd3, 32'hFFFFFFFC, 1'b0);
        applyStimulus(1'b1, 32'h123452B7, 32'h10C, 1'b1, 1'b0);
        step();
        checkEntry("lui", 32'h10C, 7'h37, 5'd5, 3'd4, 32'h12345000, 1'b0);
        applyStimulus(1'b1, 32'h001000EF, 32'h110, 1'b1, 1'b0);
        step();
        checkEntry("jal", 32'h110, 7'h6F, 5'd1, 3'd5, 32'h800, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("drain.valid", 64'(out_valid), 64'(1'b0));

        // Stall: two accepted, third blocked, then drain in order.
        applyStimulus(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        step();
        checkEntry("stall1", 32'h200, 7'h13, 5'd2, 3'd1, 32'h1, 1'b0);
        checkOutput("stall1.ready", 64'(in_ready), 64'(1'b1));
        applyStimulus(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        step();
        checkOutput("stall2.ready", 64'(in_ready), 64'(1'b0));
        checkEntry("stall2.hold", 32'h200, 7'h13, 5'd2, 3'd1, 32'h1, 1'b0);
        applyStimulus(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        step();
        checkOutput("stall3.ready", 64'(in_ready), 64'(1'b0));
        checkEntry("stall3.hold", 32'h200, 7'h13, 5'd2, 3'd1, 32'h1, 1'b0);
        applyStimulus(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        step();
        checkEntry("drain2", 32'h204, 7'h13, 5'd3, 3'd1, 32'h2, 1'b0);
        checkOutput("drain2.ready", 64'(in_ready), 64'(1'b1));
        step();
        checkEntry("drain3", 32'h208, 7'h13, 5'd4, 3'd1, 32'h3, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("drain.empty", 64'(out_valid), 64'(1'b0));

        // Flush from TWO occupancy with an instruction presented.
        applyStimulus(1'b1, 32'h00500293, 32'h300, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h00600313, 32'h304, 1'b0, 1'b0);
        step();
        checkOutput("pre_flush.ready", 64'(in_ready), 64'(1'b0));
        applyStimulus(1'b1, 32'h00700393, 32'h308, 1'b0, 1'b1);
        step();
        checkOutput("flush.valid", 64'(out_valid), 64'(1'b0));
        checkOutput("flush.ready", 64'(in_ready),  64'(1'b1));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("post_flush.valid", 64'(out_valid), 64'(1'b0));
        end

        // BAD instructions on both instances.
        applyStimulus(1'b1, 32'h00000000, 32'h400, 1'b1, 1'b0);
        step();
        checkEntry("bad0", 32'h400, 7'h00, 5'd0, 3'd7, 32'h0, 1'b1);
        checkOutput("bad0.noill.illegal", 64'(n_out_illegal), 64'(1'b0));
        checkOutput("bad0.noill.fmt",     64'(n_out_fmt),     64'(3'd7));
        applyStimulus(1'b1, 32'h0000007F, 32'h404, 1'b1, 1'b0);
        step();
        checkEntry("bad7f", 32'h404, 7'h7F, 5'd0, 3'd7, 32'h0, 1'b1);
        checkOutput("bad7f.noill.illegal", 64'(n_out_illegal), 64'(1'b0));
        checkOutput("bad7f.noill.valid",   64'(n_out_valid),   64'(1'b1));

        // Asynchronous reset mid-operation clears everything at once.
        applyStimulus(1'b1, 32'hFFF00093, 32'h500, 1'b0, 1'b0);
        step();
        checkOutput("pre_rst.valid", 64'(out_valid), 64'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst.valid",  64'(out_valid),  64'(1'b0));
        checkOutput("async_rst.ready",  64'(in_ready),   64'(1'b1));
        checkOutput("async_rst.opcode", 64'(out_opcode), 64'(7'h0));
        checkOutput("async_rst.imm",    64'(out_imm),    64'(32'h0));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        step();
        checkOutput("after_rst.valid", 64'(out_valid), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
